crc_frame_sequencer: RTL and testbench



---
 rtl/crc_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_crc_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer: frame-level CRC controller. Message words arrive over a
// valid/ready handshake and are shifted MSB-first, one bit per clock, into a
// non-reflected bit-serial CRC LFSR. The LFSR is seeded at each frame start.
// The final XOR is applied when the last word of a frame finishes shifting.
module crc_frame_sequencer #(
   parameter int                 CRC_W   = 32,
   parameter logic [CRC_W-1:0]   POLY    = 32'h04C11DB7,
   parameter logic [CRC_W-1:0]   INIT    = 32'hFFFFFFFF,
   parameter logic [CRC_W-1:0]   XOR_OUT = 32'h00000000,
   parameter int                 WORD_W  = 8,
   parameter int                 LEN_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              abort,
   output logic              busy,
   output logic [CRC_W-1:0]  crc_out,
   output logic [LEN_W-1:0]  crc_len,
   output logic              crc_valid
);

   localparam int CNT_W = $clog2(WORD_W + 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t             state_q,     state_d;
   logic [CRC_W-1:0]   lfsr_q,      lfsr_d;
   logic [WORD_W-1:0]  shreg_q,     shreg_d;
   logic [CNT_W-1:0]   bitcnt_q,    bitcnt_d;
   logic               last_q,      last_d;
   logic [LEN_W-1:0]   wcnt_q,      wcnt_d;
   logic [CRC_W-1:0]   crc_out_q,   crc_out_d;
   logic [LEN_W-1:0]   crc_len_q,   crc_len_d;
   logic               crc_valid_q, crc_valid_d;

   logic               fb;
   logic [CRC_W-1:0]   lfsr_next;

   // One LFSR step: feed back the CRC MSB XORed with the current message bit.
   always_comb begin
      fb        = lfsr_q[CRC_W-1] ^ shreg_q[WORD_W-1];
      lfsr_next = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   // Next-state logic; abort overrides everything except the held CRC result.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      last_d      = last_q;
      wcnt_d      = wcnt_q;
      crc_out_d   = crc_out_q;
      crc_len_d   = crc_len_q;
      crc_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               shreg_d  = in_data;
               last_d   = in_last;
               bitcnt_d = CNT_W'(WORD_W);
               wcnt_d   = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            lfsr_d   = lfsr_next;
            shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 1'b1;
            if (bitcnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (last_q) begin
                  crc_out_d   = lfsr_next ^ XOR_OUT;
                  crc_len_d   = wcnt_q;
                  crc_valid_d = 1'b1;
                  lfsr_d      = INIT;
                  wcnt_d      = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d     = ST_IDLE;
         lfsr_d      = INIT;
         wcnt_d      = '0;
         crc_out_d   = crc_out_q;
         crc_len_d   = crc_len_q;
         crc_valid_d = 1'b0;
      end
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= INIT;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         last_q      <= 1'b0;
         wcnt_q      <= '0;
         crc_out_q   <= '0;
         crc_len_q   <= '0;
         crc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         last_q      <= last_d;
         wcnt_q      <= wcnt_d;
         crc_out_q   <= crc_out_d;
         crc_len_q   <= crc_len_d;
         crc_valid_q <= crc_valid_d;
      end
   end

   // Handshake and status outputs derived from the registered state.
   always_comb begin
      in_ready  = (state_q == ST_IDLE) && !rst;
      busy      = (state_q == ST_SHIFT) || (wcnt_q != '0);
      crc_out   = crc_out_q;
      crc_len   = crc_len_q;
      crc_valid = crc_valid_q;
   end

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Testbench for crc_frame_sequencer: two instances, one with XOR_OUT = 0 and
// one with XOR_OUT = all-ones, driven from shared stimulus. Expected results
// go into per-instance scoreboard queues when a frame is driven and are
// compared whenever an instance raises crc_valid.
module tb_crc_frame_sequencer;

   localparam logic [31:0] POLY = 32'h04C11DB7;

   typedef struct {
      logic [31:0] crc;
      logic [15:0] len;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        abort = 1'b0;

   logic        in_ready,  busy,  crc_valid;
   logic [31:0] crc_out;
   logic [15:0] crc_len;
   logic        in_ready_x, busy_x, crc_valid_x;
   logic [31:0] crc_out_x;
   logic [15:0] crc_len_x;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int xfer_count = 0;
   int last_xfer_edge = 0;
   int shift_left = 0;
   int ready_violations = 0;
   bit prev_valid = 1'b0;
   bit prev_valid_x = 1'b0;

   exp_t sb_q[$];
   exp_t sbx_q[$];
   int   valid_edges[$];

   logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                           8'h36, 8'h37, 8'h38, 8'h39};

   crc_frame_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .abort     (abort),
      .busy      (busy),
      .crc_out   (crc_out),
      .crc_len   (crc_len),
      .crc_valid (crc_valid)
   );

   crc_frame_sequencer #(.XOR_OUT(32'hFFFFFFFF)) dut_x (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready_x),
      .abort     (abort),
      .busy      (busy_x),
      .crc_out   (crc_out_x),
      .crc_len   (crc_len_x),
      .crc_valid (crc_valid_x)
   );

   // Free-running clock and an edge counter used for latency checks.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Reference MSB-first, non-reflected CRC step over one byte.
   function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      logic        f;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         f = r[31] ^ b[i];
         r = {r[30:0], 1'b0} ^ (f ? POLY : 32'h0);
      end
      return r;
   endfunction

   // Monitor: handshake bookkeeping, ready-during-shift watch, scoreboard pops.
   always @(negedge clk) begin
      if (shift_left > 0) begin
         if (in_ready) ready_violations++;
         shift_left--;
      end
      if (in_valid && in_ready && !abort && !rst) begin
         xfer_count++;
         last_xfer_edge = cyc + 1;
         shift_left = 8;
      end
      if (prev_valid) checkOutput("valid_pulse", crc_valid, 1'b0);
      if (prev_valid_x) checkOutput("valid_pulse_x", crc_valid_x, 1'b0);
      prev_valid = crc_valid;
      prev_valid_x = crc_valid_x;
      if (crc_valid) begin
         valid_edges.push_back(cyc);
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_valid", crc_valid, 1'b0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("crc_out", crc_out, e.crc);
            checkOutput("crc_len", crc_len, e.len);
         end
      end
      if (crc_valid_x) begin
         if (sbx_q.size() == 0) begin
            checkOutput("unexpected_valid_x", crc_valid_x, 1'b0);
         end else begin
            exp_t e;
            e = sbx_q.pop_front();
            checkOutput("crc_out_x", crc_out_x, e.crc);
            checkOutput("crc_len_x", crc_len_x, e.len);
         end
      end
   end

   // Drive one word (after an optional idle gap) and wait for its transfer edge.
   task automatic applyStimulus(input logic [7:0] b, input bit last, input int gap);
      int n;
      @(negedge clk);
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_data  = b;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) checkOutput("ready_timeout", in_ready, 1'b1);
      @(posedge clk);
   endtask

   // Send "123456789" as one frame and queue its expected results.
   task automatic sendFrame(input int gap_max, output int first_edge);
      exp_t e;
      e.crc = 32'h0376E6E7; e.len = 16'd9; sb_q.push_back(e);
      e.crc = 32'hFC891918; sbx_q.push_back(e);
      first_edge = 0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(msg[i], (i == 8), (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
         if (i == 0) first_edge = last_xfer_edge;
      end
   endtask

   // Wait (bounded) for all queued results to be consumed.
   task automatic drain();
      int n;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      n = 0;
      while ((sb_q.size() != 0 || sbx_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", sb_q.size() + sbx_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int f1, f2, x0;
      logic [31:0] raw;
      exp_t e;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_crc_out", crc_out, 0);
      checkOutput("rst_crc_len", crc_len, 0);
      checkOutput("rst_crc_valid", crc_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1 checkOutput("post_rst_in_ready", in_ready, 1);

      // Single frame, back-to-back words, latency of first transfer to valid.
      valid_edges.delete();
      sendFrame(0, f1);
      drain();
      checkOutput("valid_count_1", valid_edges.size(), 1);
      checkOutput("latency", valid_edges[0] - f1, 80);
      checkOutput("busy_after_frame", busy, 0);

      // Two back-to-back frames: the second starts in the crc_valid cycle.
      valid_edges.delete();
      sendFrame(0, f1);
      sendFrame(0, f2);
      drain();
      checkOutput("b2b_valid_count", valid_edges.size(), 2);
      checkOutput("b2b_gap", f2 - valid_edges[0], 1);

      // Abort during the 5th byte's shift, then resend the frame.
      for (int i = 0; i < 5; i++) applyStimulus(msg[i], 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_keeps_len", crc_len, 9);
      sendFrame(0, f1);
      drain();

      // Abort exactly on the final-bit edge of the last word.
      for (int i = 0; i < 8; i++) applyStimulus(msg[i], 1'b0, 0);
      applyStimulus(msg[8], 1'b1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("final_abort_no_valid", crc_valid, 0);
      checkOutput("final_abort_crc_held", crc_out, 32'h0376E6E7);
      checkOutput("final_abort_crc_held_x", crc_out_x, 32'hFC891918);
      checkOutput("final_abort_busy", busy, 0);
      repeat (3) @(negedge clk);

      // Single-word frame.
      raw = crcStep(32'hFFFFFFFF, 8'hA5);
      e.crc = raw; e.len = 16'd1; sb_q.push_back(e);
      e.crc = raw ^ 32'hFFFFFFFF; sbx_q.push_back(e);
      applyStimulus(8'hA5, 1'b1, 0);
      drain();

      // Reset between words of a frame.
      for (int i = 0; i < 3; i++) applyStimulus(msg[i], 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("busy_between_words", busy, 1);
      rst = 1'b1;
      #1 checkOutput("ready_in_rst", in_ready, 0);
      @(negedge clk);
      checkOutput("midrst_crc_out", crc_out, 0);
      checkOutput("midrst_crc_len", crc_len, 0);
      checkOutput("midrst_busy", busy, 0);
      rst = 1'b0;
      #1 checkOutput("midrst_ready_after", in_ready, 1);
      sendFrame(0, f1);
      drain();

      // Random gaps between words; count transfers and watch in_ready.
      ready_violations = 0;
      x0 = xfer_count;
      sendFrame(3, f1);
      drain();
      checkOutput("random_xfers", xfer_count - x0, 9);
      checkOutput("ready_during_shift", ready_violations, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
